cop0_exception_sequencer: RTL and testbench

- Drives the COP0 register file write port, and its combinational read port, to carry out exception entry and ERET return.
- Read-modify-writes EPC, BadVAddr, Cause and Status in a fixed order, computes the exception vector from EBase, then issues a one-cycle PC redirect to the fetch stage.
- Sits between the pipeline's exception/ERET detection logic and register_cop0; it is the only writer of COP0 during exception handling.

---
 rtl/cop0_exception_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cop0_exception_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop0_exception_sequencer.sv
// COP0 exception-entry / ERET sequencer: walks a fixed read-modify-write order
// over EPC, BadVAddr, Cause and Status, then issues a one-cycle PC redirect.
module cop0_exception_sequencer #(
  parameter logic [11:0] VEC_OFFSET = 12'h180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_badvaddr_valid,
  input  logic        eret_valid,
  output logic        req_ready,
  output logic        busy,
  output logic        cop0_we,
  output logic [4:0]  cop0_write_rd,
  output logic [2:0]  cop0_write_sel,
  output logic [31:0] cop0_din,
  output logic [4:0]  cop0_read_rd,
  output logic [2:0]  cop0_read_sel,
  input  logic [31:0] cop0_dout,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [4:0] RD_BADVADDR = 5'd8;
  localparam logic [4:0] RD_STATUS   = 5'd12;
  localparam logic [4:0] RD_CAUSE    = 5'd13;
  localparam logic [4:0] RD_EPC      = 5'd14;
  localparam logic [4:0] RD_EBASE    = 5'd15;
  localparam logic [4:0] RD_ERROREPC = 5'd30;

  typedef enum logic [3:0] {
    S_IDLE,
    S_X_CHK,
    S_X_EPC,
    S_X_BVA,
    S_X_CAUSE,
    S_X_STATUS,
    S_X_VEC,
    S_REDIR,
    S_E_CHK,
    S_E_TGT,
    S_E_CLR
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic        exc_bd_q, exc_bd_d;
  logic [31:0] exc_badvaddr_q, exc_badvaddr_d;
  logic        exc_bva_valid_q, exc_bva_valid_d;
  logic        exl_q, exl_d;
  logic        erl_q, erl_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      exc_code_q      <= '0;
      exc_pc_q        <= '0;
      exc_bd_q        <= 1'b0;
      exc_badvaddr_q  <= '0;
      exc_bva_valid_q <= 1'b0;
      exl_q           <= 1'b0;
      erl_q           <= 1'b0;
      redirect_pc_q   <= '0;
    end else begin
      state_q         <= state_d;
      exc_code_q      <= exc_code_d;
      exc_pc_q        <= exc_pc_d;
      exc_bd_q        <= exc_bd_d;
      exc_badvaddr_q  <= exc_badvaddr_d;
      exc_bva_valid_q <= exc_bva_valid_d;
      exl_q           <= exl_d;
      erl_q           <= erl_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    exc_code_d      = exc_code_q;
    exc_pc_d        = exc_pc_q;
    exc_bd_d        = exc_bd_q;
    exc_badvaddr_d  = exc_badvaddr_q;
    exc_bva_valid_d = exc_bva_valid_q;
    exl_d           = exl_q;
    erl_d           = erl_q;
    redirect_pc_d   = redirect_pc_q;
    cop0_we         = 1'b0;
    cop0_write_rd   = '0;
    cop0_write_sel  = '0;
    cop0_din        = '0;
    cop0_read_rd    = '0;
    cop0_read_sel   = '0;
    redirect_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Exception has priority; a simultaneous ERET stays pending at its source.
        if (exc_valid) begin
          exc_code_d      = exc_code;
          exc_pc_d        = exc_pc;
          exc_bd_d        = exc_bd;
          exc_badvaddr_d  = exc_badvaddr;
          exc_bva_valid_d = exc_badvaddr_valid;
          state_d         = S_X_CHK;
        end else if (eret_valid) begin
          state_d = S_E_CHK;
        end
      end
      S_X_CHK: begin
        cop0_read_rd = RD_STATUS;
        exl_d        = cop0_dout[1];
        state_d      = S_X_EPC;
      end
      S_X_EPC: begin
        if (!exl_q) begin
          cop0_we       = 1'b1;
          cop0_write_rd = RD_EPC;
          cop0_din      = exc_bd_q ? (exc_pc_q - 32'd4) : exc_pc_q;
        end
        state_d = S_X_BVA;
      end
      S_X_BVA: begin
        if (exc_bva_valid_q) begin
          cop0_we       = 1'b1;
          cop0_write_rd = RD_BADVADDR;
          cop0_din      = exc_badvaddr_q;
        end
        state_d = S_X_CAUSE;
      end
      S_X_CAUSE: begin
        cop0_read_rd  = RD_CAUSE;
        cop0_we       = 1'b1;
        cop0_write_rd = RD_CAUSE;
        cop0_din      = {(exl_q ? cop0_dout[31] : exc_bd_q), cop0_dout[30:7],
                         exc_code_q, cop0_dout[1:0]};
        state_d       = S_X_STATUS;
      end
      S_X_STATUS: begin
        cop0_read_rd  = RD_STATUS;
        cop0_we       = 1'b1;
        cop0_write_rd = RD_STATUS;
        cop0_din      = cop0_dout | 32'h0000_0002;
        state_d       = S_X_VEC;
      end
      S_X_VEC: begin
        cop0_read_rd  = RD_EBASE;
        cop0_read_sel = 3'd1;
        redirect_pc_d = {cop0_dout[31:12], VEC_OFFSET};
        state_d       = S_REDIR;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        state_d        = S_IDLE;
      end
      S_E_CHK: begin
        cop0_read_rd = RD_STATUS;
        erl_d        = cop0_dout[2];
        state_d      = S_E_TGT;
      end
      S_E_TGT: begin
        cop0_read_rd  = erl_q ? RD_ERROREPC : RD_EPC;
        redirect_pc_d = cop0_dout;
        state_d       = S_E_CLR;
      end
      S_E_CLR: begin
        cop0_read_rd  = RD_STATUS;
        cop0_we       = 1'b1;
        cop0_write_rd = RD_STATUS;
        cop0_din      = erl_q ? (cop0_dout & ~32'h0000_0004)
                              : (cop0_dout & ~32'h0000_0002);
        state_d       = S_REDIR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_cop0_exception_sequencer.sv
// Directed bench for cop0_exception_sequencer with a COP0 register model and
// scoreboard queues of expected writes and redirects (cycle, target, data).
module tb_cop0_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid, exc_bd, exc_badvaddr_valid, eret_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr;
  logic        req_ready, busy, cop0_we, redirect_valid;
  logic [4:0]  cop0_write_rd, cop0_read_rd;
  logic [2:0]  cop0_write_sel, cop0_read_sel;
  logic [31:0] cop0_din, cop0_dout, redirect_pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;

  typedef struct {
    int          c;
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] d;
  } wr_t;
  typedef struct {
    int          c;
    logic [31:0] pc;
  } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  cop0_exception_sequencer #(.VEC_OFFSET(12'h180)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .exc_badvaddr_valid(exc_badvaddr_valid),
    .eret_valid(eret_valid), .req_ready(req_ready), .busy(busy),
    .cop0_we(cop0_we), .cop0_write_rd(cop0_write_rd), .cop0_write_sel(cop0_write_sel),
    .cop0_din(cop0_din), .cop0_read_rd(cop0_read_rd), .cop0_read_sel(cop0_read_sel),
    .cop0_dout(cop0_dout), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // COP0 register model, written only at posedge; presets use the same port.
  logic [31:0] regs [256] = '{default: 32'h0};
  logic        pre_we = 1'b0;
  logic [7:0]  pre_a = 8'h0;
  logic [31:0] pre_d = 32'h0;
  always @(posedge clk) begin
    if (pre_we) regs[pre_a] <= pre_d;
    else if (cop0_we) regs[{cop0_write_rd, cop0_write_sel}] <= cop0_din;
  end
  assign cop0_dout = regs[{cop0_read_rd, cop0_read_sel}];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cause(input logic [31:0] old, input logic b31,
                                            input logic [4:0] code);
    return (old & 32'h7FFF_FF83) | {b31, 31'b0} | {25'b0, code, 2'b0};
  endfunction

  function automatic logic [31:0] rget(input logic [4:0] rd, input logic [2:0] sel);
    return regs[{rd, sel}];
  endfunction

  task automatic push_wr(input int c, input logic [4:0] rd, input logic [2:0] sel,
                         input logic [31:0] d);
    wr_t e;
    e.c = c; e.rd = rd; e.sel = sel; e.d = d;
    wq.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [31:0] pc);
    rd_t e;
    e.c = c; e.pc = pc;
    rq.push_back(e);
  endtask

  task automatic preset(input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] d);
    @(negedge clk);
    pre_a = {rd, sel}; pre_d = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || wq.size() != 0 || rq.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_busy", 64'(busy), 64'd0);
    chk("wait_idle_wq_left", 64'(wq.size()), 64'd0);
    chk("wait_idle_rq_left", 64'(rq.size()), 64'd0);
  endtask

  task automatic drive_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic [31:0] bva, input logic bvv);
    exc_code = code; exc_pc = pc; exc_bd = bd;
    exc_badvaddr = bva; exc_badvaddr_valid = bvv; exc_valid = 1'b1;
  endtask

  // Scoreboard monitor: every write and redirect must match the queue head.
  always @(negedge clk) begin
    if (cop0_we) begin
      wr_t e;
      logic legal;
      wr_cnt++;
      legal = ({cop0_write_rd, cop0_write_sel} == {5'd14, 3'd0}) ||
              ({cop0_write_rd, cop0_write_sel} == {5'd8, 3'd0}) ||
              ({cop0_write_rd, cop0_write_sel} == {5'd13, 3'd0}) ||
              ({cop0_write_rd, cop0_write_sel} == {5'd12, 3'd0});
      chk("wr_target_legal", 64'(legal), 64'd1);
      checks++;
      assert (wq.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write: observed rd=%0d sel=%0d din=%0h cyc=%0d expected none",
               cop0_write_rd, cop0_write_sel, cop0_din, cyc);
      end
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(e.c));
        chk("wr_target", 64'({cop0_write_rd, cop0_write_sel}), 64'({e.rd, e.sel}));
        chk("wr_data", 64'(cop0_din), 64'(e.d));
      end
    end else begin
      chk("wr_fields_zero", {24'b0, cop0_write_rd, cop0_write_sel, cop0_din}, 64'd0);
    end
    if (redirect_valid) begin
      rd_t r;
      checks++;
      assert (rq.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_redirect: observed pc=%0h cyc=%0d expected none",
               redirect_pc, cyc);
      end
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("redir_cycle", 64'(cyc), 64'(r.c));
        chk("redir_pc", 64'(redirect_pc), 64'(r.pc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int w0;
    reset = 1'b0;
    exc_valid = 1'b0; eret_valid = 1'b0; exc_bd = 1'b0; exc_badvaddr_valid = 1'b0;
    exc_code = '0; exc_pc = '0; exc_badvaddr = '0;

    preset(5'd12, 3'd0, 32'h0040_0004);
    preset(5'd30, 3'd0, 32'hBFC0_0010);
    preset(5'd15, 3'd1, 32'h8000_0000);
    preset(5'd13, 3'd0, 32'h0000_0300);
    @(negedge clk);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_cop0_we", 64'(cop0_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // ERET with ERL=1: target ErrorEPC, clear ERL.
    @(negedge clk);
    base = cyc; w0 = wr_cnt;
    chk("t1_req_ready", 64'(req_ready), 64'd1);
    push_wr(base + 3, 5'd12, 3'd0, 32'h0040_0000);
    push_rd(base + 4, 32'hBFC0_0010);
    eret_valid = 1'b1;
    @(posedge clk); #1 eret_valid = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_req_ready_busy", 64'(req_ready), 64'd0);
    wait_idle(20);
    chk("t1_we_count", 64'(wr_cnt - w0), 64'd1);
    chk("t1_status", 64'(rget(5'd12, 3'd0)), 64'h0040_0000);

    // Exception with EXL=0 in a delay slot.
    @(negedge clk);
    base = cyc;
    push_wr(base + 2, 5'd14, 3'd0, 32'h8000_1000);
    push_wr(base + 3, 5'd8, 3'd0, 32'h0000_0003);
    push_wr(base + 4, 5'd13, 3'd0, exp_cause(32'h0000_0300, 1'b1, 5'd4));
    push_wr(base + 5, 5'd12, 3'd0, 32'h0040_0002);
    push_rd(base + 7, 32'h8000_0180);
    drive_exc(5'd4, 32'h8000_1004, 1'b1, 32'h0000_0003, 1'b1);
    @(posedge clk); #1 exc_valid = 1'b0;
    wait_idle(20);
    chk("t2_epc", 64'(rget(5'd14, 3'd0)), 64'h8000_1000);
    chk("t2_cause", 64'(rget(5'd13, 3'd0)), 64'h8000_0310);
    chk("t2_status", 64'(rget(5'd12, 3'd0)), 64'h0040_0002);
    chk("t2_req_ready", 64'(req_ready), 64'd1);

    // Nested exception (EXL already set): no EPC write, Cause[31] kept.
    preset(5'd13, 3'd0, 32'h0000_0310);
    @(negedge clk);
    base = cyc;
    push_wr(base + 3, 5'd8, 3'd0, 32'h0000_0003);
    push_wr(base + 4, 5'd13, 3'd0, exp_cause(32'h0000_0310, 1'b0, 5'd5));
    push_wr(base + 5, 5'd12, 3'd0, 32'h0040_0002);
    push_rd(base + 7, 32'h8000_0180);
    drive_exc(5'd5, 32'h8000_1004, 1'b1, 32'h0000_0003, 1'b1);
    @(posedge clk); #1 exc_valid = 1'b0;
    wait_idle(20);
    chk("t3_epc_kept", 64'(rget(5'd14, 3'd0)), 64'h8000_1000);
    chk("t3_cause", 64'(rget(5'd13, 3'd0)), 64'h0000_0314);

    // Simultaneous exception + ERET; no BadVAddr write; ERET follows in IDLE cycle 8.
    preset(5'd12, 3'd0, 32'h0000_0000);
    preset(5'd13, 3'd0, 32'h0000_0000);
    @(negedge clk);
    base = cyc;
    push_wr(base + 2, 5'd14, 3'd0, 32'h8000_2000);
    push_wr(base + 4, 5'd13, 3'd0, exp_cause(32'h0, 1'b0, 5'd10));
    push_wr(base + 5, 5'd12, 3'd0, 32'h0000_0002);
    push_rd(base + 7, 32'h8000_0180);
    push_wr(base + 11, 5'd12, 3'd0, 32'h0000_0000);
    push_rd(base + 12, 32'h8000_2000);
    drive_exc(5'd10, 32'h8000_2000, 1'b0, 32'hDEAD_BEEF, 1'b0);
    eret_valid = 1'b1;
    @(posedge clk); #1 exc_valid = 1'b0;
    while (cyc < base + 9) begin
      @(posedge clk); #1;
    end
    eret_valid = 1'b0;
    wait_idle(30);
    chk("t4_badvaddr_kept", 64'(rget(5'd8, 3'd0)), 64'h0000_0003);
    chk("t4_status", 64'(rget(5'd12, 3'd0)), 64'h0000_0000);
    chk("t4_cause", 64'(rget(5'd13, 3'd0)), 64'h0000_0028);

    // Reset asserted while in X_CAUSE: sequence aborts, earlier writes stay.
    @(negedge clk);
    base = cyc;
    push_wr(base + 2, 5'd14, 3'd0, 32'h8000_3000);
    push_wr(base + 3, 5'd8, 3'd0, 32'h0000_1234);
    drive_exc(5'd3, 32'h8000_3000, 1'b0, 32'h0000_1234, 1'b1);
    @(posedge clk); #1 exc_valid = 1'b0;
    while (cyc < base + 4) begin
      @(posedge clk); #2;
    end
    chk("t5_pre_reset_we", 64'(cop0_we), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_we", 64'(cop0_we), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_ready", 64'(req_ready), 64'd1);
    chk("t5_rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("t5_rst_redirect_pc", 64'(redirect_pc), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_wq_left", 64'(wq.size()), 64'd0);
    chk("t5_epc", 64'(rget(5'd14, 3'd0)), 64'h8000_3000);
    chk("t5_badvaddr", 64'(rget(5'd8, 3'd0)), 64'h0000_1234);
    chk("t5_cause", 64'(rget(5'd13, 3'd0)), 64'h0000_0028);
    chk("t5_status", 64'(rget(5'd12, 3'd0)), 64'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
